dual_issue_scheduler: RTL and testbench



---
 rtl/dual_issue_scheduler_pkg.sv | 15 +
 rtl/dual_issue_scheduler_if.sv | 46 ++++
 rtl/dual_issue_scheduler_sat_counter.sv | 18 +
 rtl/dual_issue_scheduler.sv | 125 ++++++++++++
 tb/tb_dual_issue_scheduler.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/dual_issue_scheduler_pkg.sv
// Shared constants for the dual-issue scheduler: issue-state encoding and the
// register-zero compare helper used by hazard detection.
package dual_issue_scheduler_pkg;

  localparam logic [0:0] ST_PAIR   = 1'b0;
  localparam logic [0:0] ST_ISSUE2 = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Register zero is hardwired, so a match against it never creates a hazard.
  function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/dual_issue_scheduler_if.sv
// Decode/EX hazard inputs, pipeline control outputs and performance counters
// exchanged between the pipeline (master) and the issue scheduler (slave).
interface dual_issue_scheduler_if #(parameter int CNT_W = 16);

  logic             pair_valid_D;
  logic             RegWrite1_D;
  logic [4:0]       Rd1_D;
  logic [4:0]       Rs2_D;
  logic [4:0]       Rt2_D;
  logic             usesRt2_D;
  logic             Mem1_D;
  logic             Mem2_D;
  logic [4:0]       Rs1_D;
  logic [4:0]       Rt1_D;
  logic             MemRead1_EX;
  logic             MemRead2_EX;
  logic [4:0]       Rt1_EX;
  logic [4:0]       Rt2_EX;
  logic             mispredict_EX;

  logic             stall_F;
  logic             stall_D;
  logic             flush_D_1;
  logic             flush_D_2;
  logic             split_active;
  logic [CNT_W-1:0] pair_cnt;
  logic [CNT_W-1:0] split_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output pair_valid_D, RegWrite1_D, Rd1_D, Rs2_D, Rt2_D, usesRt2_D,
           Mem1_D, Mem2_D, Rs1_D, Rt1_D, MemRead1_EX, MemRead2_EX,
           Rt1_EX, Rt2_EX, mispredict_EX,
    input  stall_F, stall_D, flush_D_1, flush_D_2, split_active,
           pair_cnt, split_cnt, stall_cnt
  );

  modport slave (
    input  pair_valid_D, RegWrite1_D, Rd1_D, Rs2_D, Rt2_D, usesRt2_D,
           Mem1_D, Mem2_D, Rs1_D, Rt1_D, MemRead1_EX, MemRead2_EX,
           Rt1_EX, Rt2_EX, mispredict_EX,
    output stall_F, stall_D, flush_D_1, flush_D_2, split_active,
           pair_cnt, split_cnt, stall_cnt
  );

endinterface

// File: rtl/dual_issue_scheduler_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (inc && (cnt != {CNT_W{1'b1}}))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/dual_issue_scheduler.sv
// Issue controller for the dual-issue pipeline: pair issue, split issue or
// load-use stall, with saturating performance counters.
//
// state  | meaning
// PAIR   | decode pair evaluated for joint issue, split or load-use stall
// ISSUE2 | slot 1 already issued; slot 2 issues once its load-use clears
module dual_issue_scheduler
  import dual_issue_scheduler_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                   clk,
  input logic                   reset,
  dual_issue_scheduler_if.slave bus
);

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic       dep;
  logic       mem2;
  logic       lu_s1;
  logic       lu_s2;
  logic       lu_all;
  logic       inc_pair;
  logic       inc_split;
  logic       inc_stall;

  assign dep = bus.RegWrite1_D && (bus.Rd1_D != REG_ZERO) &&
               ((bus.Rd1_D == bus.Rs2_D) ||
                (bus.usesRt2_D && (bus.Rd1_D == bus.Rt2_D)));

  assign mem2 = bus.Mem1_D && bus.Mem2_D;

  // Load-use split by consuming slot so ISSUE2 can ignore the issued slot 1.
  assign lu_s1 = (bus.MemRead1_EX && (reg_hit(bus.Rt1_EX, bus.Rs1_D) ||
                                      reg_hit(bus.Rt1_EX, bus.Rt1_D))) ||
                 (bus.MemRead2_EX && (reg_hit(bus.Rt2_EX, bus.Rs1_D) ||
                                      reg_hit(bus.Rt2_EX, bus.Rt1_D)));

  assign lu_s2 = (bus.MemRead1_EX && (reg_hit(bus.Rt1_EX, bus.Rs2_D) ||
                                      reg_hit(bus.Rt1_EX, bus.Rt2_D))) ||
                 (bus.MemRead2_EX && (reg_hit(bus.Rt2_EX, bus.Rs2_D) ||
                                      reg_hit(bus.Rt2_EX, bus.Rt2_D)));

  assign lu_all = lu_s1 || lu_s2;

  always_comb begin
    bus.stall_F   = 1'b0;
    bus.stall_D   = 1'b0;
    bus.flush_D_1 = 1'b0;
    bus.flush_D_2 = 1'b0;
    state_nxt     = state;
    inc_pair      = 1'b0;
    inc_split     = 1'b0;
    inc_stall     = 1'b0;

    if (reset) begin
      state_nxt = ST_PAIR;
    end else if (bus.mispredict_EX) begin
      bus.flush_D_1 = 1'b1;
      bus.flush_D_2 = 1'b1;
      state_nxt     = ST_PAIR;
    end else if (!bus.pair_valid_D) begin
      state_nxt = ST_PAIR;
    end else if (state == ST_PAIR) begin
      if (lu_all) begin
        bus.stall_F   = 1'b1;
        bus.stall_D   = 1'b1;
        bus.flush_D_1 = 1'b1;
        bus.flush_D_2 = 1'b1;
        inc_stall     = 1'b1;
      end else if (dep || mem2) begin
        bus.stall_F   = 1'b1;
        bus.stall_D   = 1'b1;
        bus.flush_D_2 = 1'b1;
        state_nxt     = ST_ISSUE2;
        inc_split     = 1'b1;
      end else begin
        inc_pair = 1'b1;
      end
    end else begin
      if (lu_s2) begin
        bus.stall_F   = 1'b1;
        bus.stall_D   = 1'b1;
        bus.flush_D_1 = 1'b1;
        bus.flush_D_2 = 1'b1;
        inc_stall     = 1'b1;
      end else begin
        bus.flush_D_1 = 1'b1;
        state_nxt     = ST_PAIR;
      end
    end
  end

  assign bus.split_active = (state == ST_ISSUE2) && !reset;

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_PAIR;
    else
      state <= state_nxt;
  end

  sat_counter #(.CNT_W(CNT_W)) u_pair_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_pair),
    .cnt   (bus.pair_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_split_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_split),
    .cnt   (bus.split_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_stall),
    .cnt   (bus.stall_cnt)
  );

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed plus random checks of the dual-issue scheduler against a rule-level
// model; a second 2-bit-counter instance shares the stimulus to hit saturation.
module tb_dual_issue_scheduler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dual_issue_scheduler_if #(.CNT_W(16)) bus ();
  dual_issue_scheduler_if #(.CNT_W(2))  bus_s ();

  assign bus_s.pair_valid_D  = bus.pair_valid_D;
  assign bus_s.RegWrite1_D   = bus.RegWrite1_D;
  assign bus_s.Rd1_D         = bus.Rd1_D;
  assign bus_s.Rs2_D         = bus.Rs2_D;
  assign bus_s.Rt2_D         = bus.Rt2_D;
  assign bus_s.usesRt2_D     = bus.usesRt2_D;
  assign bus_s.Mem1_D        = bus.Mem1_D;
  assign bus_s.Mem2_D        = bus.Mem2_D;
  assign bus_s.Rs1_D         = bus.Rs1_D;
  assign bus_s.Rt1_D         = bus.Rt1_D;
  assign bus_s.MemRead1_EX   = bus.MemRead1_EX;
  assign bus_s.MemRead2_EX   = bus.MemRead2_EX;
  assign bus_s.Rt1_EX        = bus.Rt1_EX;
  assign bus_s.Rt2_EX        = bus.Rt2_EX;
  assign bus_s.mispredict_EX = bus.mispredict_EX;

  dual_issue_scheduler #(.CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dual_issue_scheduler #(.CNT_W(2)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  int errors = 0;
  int checks = 0;

  // Model: split flag plus raw event counts; saturation applied on compare.
  bit m_split = 1'b0;
  int m_pair  = 0;
  int m_splc  = 0;
  int m_stall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input logic [4:0] ex, input logic [4:0] r);
    return (ex != 5'd0) && (ex == r);
  endfunction

  function automatic int sat(input int v, input int cap);
    return (v > cap) ? cap : v;
  endfunction

  task automatic clear_inputs();
    reset             = 1'b0;
    bus.pair_valid_D  = 1'b1;
    bus.RegWrite1_D   = 1'b0;
    bus.Rd1_D         = 5'd0;
    bus.Rs2_D         = 5'd0;
    bus.Rt2_D         = 5'd0;
    bus.usesRt2_D     = 1'b0;
    bus.Mem1_D        = 1'b0;
    bus.Mem2_D        = 1'b0;
    bus.Rs1_D         = 5'd0;
    bus.Rt1_D         = 5'd0;
    bus.MemRead1_EX   = 1'b0;
    bus.MemRead2_EX   = 1'b0;
    bus.Rt1_EX        = 5'd0;
    bus.Rt2_EX        = 5'd0;
    bus.mispredict_EX = 1'b0;
  endtask

  // One clock: check control outputs before the edge, counters after it.
  task automatic step(input string tag);
    bit dep, mem2, lu_any, lu_slot2;
    bit sf, sd, f1, f2, sa, nxt;
    int d_pair, d_splc, d_stall;
    dep = bus.RegWrite1_D && bus.Rd1_D != 5'd0 &&
          (bus.Rd1_D == bus.Rs2_D || (bus.usesRt2_D && bus.Rd1_D == bus.Rt2_D));
    mem2 = bus.Mem1_D && bus.Mem2_D;
    lu_slot2 = (bus.MemRead1_EX && (hit(bus.Rt1_EX, bus.Rs2_D) || hit(bus.Rt1_EX, bus.Rt2_D))) ||
               (bus.MemRead2_EX && (hit(bus.Rt2_EX, bus.Rs2_D) || hit(bus.Rt2_EX, bus.Rt2_D)));
    lu_any = lu_slot2 ||
             (bus.MemRead1_EX && (hit(bus.Rt1_EX, bus.Rs1_D) || hit(bus.Rt1_EX, bus.Rt1_D))) ||
             (bus.MemRead2_EX && (hit(bus.Rt2_EX, bus.Rs1_D) || hit(bus.Rt2_EX, bus.Rt1_D)));
    {sf, sd, f1, f2} = 4'b0000;
    d_pair = 0; d_splc = 0; d_stall = 0;
    nxt = m_split;
    sa  = m_split && !reset;
    if (reset) begin
      nxt = 1'b0;
    end else if (bus.mispredict_EX) begin
      {f1, f2} = 2'b11;
      nxt = 1'b0;
    end else if (!bus.pair_valid_D) begin
      nxt = 1'b0;
    end else if (!m_split) begin
      if (lu_any) begin
        {sf, sd, f1, f2} = 4'b1111;
        d_stall = 1;
      end else if (dep || mem2) begin
        {sf, sd, f2} = 3'b111;
        nxt = 1'b1;
        d_splc = 1;
      end else begin
        d_pair = 1;
      end
    end else begin
      if (lu_slot2) begin
        {sf, sd, f1, f2} = 4'b1111;
        d_stall = 1;
      end else begin
        f1 = 1'b1;
        nxt = 1'b0;
      end
    end
    #1;
    chk({tag, "/ctl"}, {27'd0, bus.stall_F, bus.stall_D, bus.flush_D_1, bus.flush_D_2, bus.split_active},
        {27'd0, sf, sd, f1, f2, sa});
    @(posedge clk);
    if (reset) begin
      m_pair = 0; m_splc = 0; m_stall = 0;
    end else begin
      m_pair += d_pair; m_splc += d_splc; m_stall += d_stall;
    end
    m_split = nxt;
    #1;
    chk({tag, "/cnt16"}, {bus.pair_cnt, bus.split_cnt},
        {16'(sat(m_pair, 65535)), 16'(sat(m_splc, 65535))});
    chk({tag, "/stall16"}, {16'd0, bus.stall_cnt}, {16'd0, 16'(sat(m_stall, 65535))});
    chk({tag, "/cnt2"}, {26'd0, bus_s.pair_cnt, bus_s.split_cnt, bus_s.stall_cnt},
        {26'd0, 2'(sat(m_pair, 3)), 2'(sat(m_splc, 3)), 2'(sat(m_stall, 3))});
  endtask

  initial begin
    clear_inputs();

    // Reset held two cycles, then one clean pair issues.
    reset = 1'b1;
    step("rst0");
    step("rst1");
    reset = 1'b0;
    step("first_pair");
    chk("first_pair_cnt", 32'(bus.pair_cnt), 32'd1);

    // Register dependency splits the pair.
    bus.RegWrite1_D = 1'b1; bus.Rd1_D = 5'd5; bus.Rs2_D = 5'd5;
    step("dep_c0");
    chk("dep_issue2", 32'(bus.split_active), 32'd1);
    step("dep_c1");
    chk("dep_split_cnt", 32'(bus.split_cnt), 32'd1);
    clear_inputs();
    step("dep_c2");

    // Single memory port forces a split; r0 dependency does not.
    bus.Mem1_D = 1'b1; bus.Mem2_D = 1'b1;
    step("mem2_c0");
    step("mem2_c1");
    clear_inputs();
    bus.RegWrite1_D = 1'b1; bus.Rd1_D = 5'd0; bus.Rs2_D = 5'd0;
    step("r0_nosplit");
    chk("r0_split_active", 32'(bus.split_active), 32'd0);

    // Load-use from slot-2 EX load on slot-1 source.
    clear_inputs();
    bus.MemRead2_EX = 1'b1; bus.Rt2_EX = 5'd7; bus.Rs1_D = 5'd7;
    step("lu_c0");
    chk("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    clear_inputs();
    step("lu_c1");

    // Mispredict while in ISSUE2 drops the split without counting.
    bus.RegWrite1_D = 1'b1; bus.Rd1_D = 5'd9; bus.usesRt2_D = 1'b1; bus.Rt2_D = 5'd9;
    step("mp_c0");
    bus.mispredict_EX = 1'b1;
    step("mp_c1");
    chk("mp_split_cnt", 32'(bus.split_cnt), 32'd3);
    clear_inputs();
    step("mp_c2");

    // Narrow counters saturate at 3.
    for (int i = 0; i < 5; i++) step("sat_pair");
    chk("sat_pair_cnt2", 32'(bus_s.pair_cnt), 32'd3);

    // Reset in the middle of a split.
    bus.Mem1_D = 1'b1; bus.Mem2_D = 1'b1;
    step("rs_c0");
    reset = 1'b1;
    step("rs_c1");
    chk("rs_counters", {8'd0, bus_s.pair_cnt, bus_s.split_cnt, bus_s.stall_cnt, bus.pair_cnt}, 32'd0);
    clear_inputs();
    step("rs_c2");

    // Random traffic with small register indices so hazards are frequent.
    for (int i = 0; i < 600; i++) begin
      reset             = ($urandom_range(0, 49) == 0);
      bus.pair_valid_D  = m_split ? 1'b1 : ($urandom_range(0, 7) != 0);
      bus.RegWrite1_D   = 1'($urandom);
      bus.Rd1_D         = 5'($urandom_range(0, 3));
      bus.Rs2_D         = 5'($urandom_range(0, 3));
      bus.Rt2_D         = 5'($urandom_range(0, 3));
      bus.usesRt2_D     = 1'($urandom);
      bus.Mem1_D        = ($urandom_range(0, 2) == 0);
      bus.Mem2_D        = ($urandom_range(0, 2) == 0);
      bus.Rs1_D         = 5'($urandom_range(0, 7));
      bus.Rt1_D         = 5'($urandom_range(0, 7));
      bus.MemRead1_EX   = ($urandom_range(0, 3) == 0);
      bus.MemRead2_EX   = ($urandom_range(0, 3) == 0);
      bus.Rt1_EX        = 5'($urandom_range(0, 7));
      bus.Rt2_EX        = 5'($urandom_range(0, 7));
      bus.mispredict_EX = ($urandom_range(0, 11) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
